// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus.
// Holds the byte RAM, decodes the I/O window at mem_a[17:16]==2'b11, and owns
// the UART TX/RX byte FIFOs, the free-running cycle counter with its read
// snapshot, and the sticky program-stop and TX-overflow flags.
module mem_io_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        program_done,
    output logic        tx_overflow
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_NEAR_FULL = (TX_AW + 1)'(TX_DEPTH - 2);

    // Storage arrays; contents are never reset, only the pointers are
    logic [7:0] r_ram   [2**RAM_AW];
    logic [7:0] r_txMem [TX_DEPTH];
    logic [7:0] r_rxMem [RX_DEPTH];

    // FIFO pointers carry an extra wrap bit to tell full from empty
    logic [TX_AW:0] r_txWr, r_txRd;
    logic [RX_AW:0] r_rxWr, r_rxRd;

    logic [31:0] r_counter;
    logic [31:0] r_snapshot;
    logic [7:0]  r_ramQ;
    logic [7:0]  r_ioQ;
    logic        r_srcRam;
    logic        r_ioBufFull;
    logic        r_programDone;
    logic        r_txOverflow;

    logic              w_io;
    logic              w_ioData;
    logic              w_ioCtr;
    logic              w_isCtr0;
    logic              w_ramWr;
    logic              w_ramRd;
    logic [RAM_AW-1:0] w_ramAddr;
    logic              w_txFull, w_txEmpty;
    logic              w_rxFull, w_rxEmpty;
    logic              w_txPushReq, w_txPush, w_txDrop, w_txPop;
    logic [7:0]        w_txPushData;
    logic              w_rxPush, w_rxPop;
    logic [TX_AW:0]    w_txCount, w_txCountNext;
    logic [7:0]        w_ioRdData;
    logic              w_unusedAddrBits;

    // Address decode: the I/O window is the top quarter of the 18-bit space
    assign w_io      = (mem_a[17:16] == 2'b11);
    assign w_ioData  = w_io && (mem_a[15:0] == 16'h0000);
    assign w_ioCtr   = w_io && (mem_a[15:2] == 14'h0001);
    assign w_isCtr0  = w_ioCtr && (mem_a[1:0] == 2'b00);
    assign w_ramWr   = !w_io && mem_wr && !rst_in;
    assign w_ramRd   = !w_io && !mem_wr;
    assign w_ramAddr = mem_a[RAM_AW-1:0];
    assign w_unusedAddrBits = &{1'b0, mem_a[31:18]};

    // FIFO status from the pointer pairs
    assign w_txEmpty = (r_txWr == r_txRd);
    assign w_txFull  = (r_txWr[TX_AW] != r_txRd[TX_AW]) &&
                       (r_txWr[TX_AW-1:0] == r_txRd[TX_AW-1:0]);
    assign w_rxEmpty = (r_rxWr == r_rxRd);
    assign w_rxFull  = (r_rxWr[RX_AW] != r_rxRd[RX_AW]) &&
                       (r_rxWr[RX_AW-1:0] == r_rxRd[RX_AW-1:0]);

    // TX pushes come from a nonzero data write or the stop write (which sends 0x00).
    // Fullness is judged before any same-cycle pop, so a pop never makes room.
    assign w_txPushReq  = mem_wr && ((w_ioData && (mem_dout != 8'h00)) || w_isCtr0);
    assign w_txPushData = w_isCtr0 ? 8'h00 : mem_dout;
    assign w_txPush     = w_txPushReq && !w_txFull;
    assign w_txDrop     = w_txPushReq && w_txFull;
    assign w_txPop      = !w_txEmpty && tx_ready;

    // RX pushes from the UART and pops from CPU reads of the data port; an empty
    // FIFO is never bypassed by a same-cycle push
    assign w_rxPush = rx_valid && !w_rxFull;
    assign w_rxPop  = w_ioData && !mem_wr && !w_rxEmpty;

    assign w_txCount     = r_txWr - r_txRd;
    assign w_txCountNext = w_txCount + {{TX_AW{1'b0}}, w_txPush} - {{TX_AW{1'b0}}, w_txPop};

    assign tx_valid       = !w_txEmpty;
    assign tx_data        = r_txMem[r_txRd[TX_AW-1:0]];
    assign rx_ready       = !w_rxFull;
    assign io_buffer_full = r_ioBufFull;
    assign program_done   = r_programDone;
    assign tx_overflow    = r_txOverflow;
    assign mem_din        = r_srcRam ? r_ramQ : r_ioQ;

    // Select the byte an I/O read returns; unmapped addresses read as zero
    always_comb begin
        w_ioRdData = 8'h00;
        if (w_ioData && !w_rxEmpty) begin
            w_ioRdData = r_rxMem[r_rxRd[RX_AW-1:0]];
        end else if (w_ioCtr) begin
            case (mem_a[1:0])
                2'b00:   w_ioRdData = r_counter[7:0];
                2'b01:   w_ioRdData = r_snapshot[15:8];
                2'b10:   w_ioRdData = r_snapshot[23:16];
                default: w_ioRdData = r_snapshot[31:24];
            endcase
        end
    end

    // RAM port: write at the edge, registered read so a write followed by a read returns the new byte
    always_ff @(posedge clk_in) begin
        if (w_ramWr) begin
            r_ram[w_ramAddr] <= mem_dout;
        end
        r_ramQ <= r_ram[w_ramAddr];
    end

    // FIFO data arrays; writes are only meaningful when the pointer also advances
    always_ff @(posedge clk_in) begin
        if (w_txPush) begin
            r_txMem[r_txWr[TX_AW-1:0]] <= w_txPushData;
        end
        if (w_rxPush) begin
            r_rxMem[r_rxWr[RX_AW-1:0]] <= rx_data;
        end
    end

    // FIFO pointers and the registered near-full flag seen by the CPU
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_txWr      <= '0;
            r_txRd      <= '0;
            r_rxWr      <= '0;
            r_rxRd      <= '0;
            r_ioBufFull <= 1'b0;
        end else begin
            if (w_txPush) r_txWr <= r_txWr + 1'b1;
            if (w_txPop)  r_txRd <= r_txRd + 1'b1;
            if (w_rxPush) r_rxWr <= r_rxWr + 1'b1;
            if (w_rxPop)  r_rxRd <= r_rxRd + 1'b1;
            r_ioBufFull <= (w_txCountNext >= TX_NEAR_FULL);
        end
    end

    // Cycle counter and the snapshot taken when the low counter byte is read
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_counter  <= '0;
            r_snapshot <= '0;
        end else begin
            r_counter <= r_counter + 32'd1;
            if (w_isCtr0 && !mem_wr) begin
                r_snapshot <= r_counter;
            end
        end
    end

    // Read-data source select; writes and reset leave the I/O path holding zero
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_srcRam <= 1'b0;
            r_ioQ    <= 8'h00;
        end else begin
            r_srcRam <= w_ramRd;
            r_ioQ    <= (w_io && !mem_wr) ? w_ioRdData : 8'h00;
        end
    end

    // Sticky status flags
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_programDone <= 1'b0;
            r_txOverflow  <= 1'b0;
        end else begin
            if (w_isCtr0 && mem_wr) r_programDone <= 1'b1;
            if (w_txDrop)           r_txOverflow  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with scoreboard queues for mem_din and
// for the bytes expected to leave through the TX handshake.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        program_done;
    logic        tx_overflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  dinQ[$];
    logic [7:0]  txQ[$];
    logic [31:0] modelCounter;
    logic [31:0] snap;

    mem_io_responder #(.RAM_AW(17), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
        .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .program_done(program_done), .tx_overflow(tx_overflow)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk_in = ~clk_in;

    // Safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One bus cycle: TX handshake scored at the falling edge, mem_din scored after the rising edge
    task automatic runCycle();
        @(negedge clk_in);
        if (tx_valid && tx_ready) begin
            if (txQ.size() == 0) begin
                checks++;
                failures++;
                $error("[TB] FAIL tx_spurious observed=0x%0h expected=no_byte", tx_data);
            end else begin
                checkOutput("tx_data", {24'h0, tx_data}, {24'h0, txQ.pop_front()});
            end
        end
        @(posedge clk_in);
        #1;
        modelCounter = rst_in ? 32'd0 : modelCounter + 32'd1;
        if (dinQ.size() != 0) begin
            checkOutput("mem_din", {24'h0, mem_din}, {24'h0, dinQ.pop_front()});
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [7:0] data,
                                 input logic [7:0] expDin);
        mem_a    = addr;
        mem_wr   = wr;
        mem_dout = data;
        dinQ.push_back(expDin);
        runCycle();
    endtask

    // Filler transaction: a RAM write, which always returns zero on mem_din
    task automatic idleCycle();
        applyStimulus(32'h0000_0100, 1'b1, 8'h00, 8'h00);
    endtask

    initial begin
        rst_in       = 1'b1;
        mem_a        = 32'h0;
        mem_dout     = 8'h0;
        mem_wr       = 1'b0;
        tx_ready     = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h0;
        modelCounter = 32'd0;

        // Reset state
        applyStimulus(32'h0000_0000, 1'b1, 8'h00, 8'h00);
        applyStimulus(32'h0000_0000, 1'b1, 8'h00, 8'h00);
        rst_in = 1'b0;
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_rx_ready", rx_ready, 1);
        checkOutput("rst_io_buffer_full", io_buffer_full, 0);
        checkOutput("rst_program_done", program_done, 0);
        checkOutput("rst_tx_overflow", tx_overflow, 0);

        // RAM write/read, back-to-back, and the top address
        applyStimulus(32'h0000_0010, 1'b1, 8'hA5, 8'h00);
        applyStimulus(32'h0000_0010, 1'b0, 8'h00, 8'hA5);
        applyStimulus(32'h0000_0011, 1'b1, 8'h5A, 8'h00);
        applyStimulus(32'h0001_FFFF, 1'b1, 8'h3C, 8'h00);
        applyStimulus(32'h0001_FFFF, 1'b0, 8'h00, 8'h3C);
        applyStimulus(32'h0000_0010, 1'b0, 8'h00, 8'hA5);
        applyStimulus(32'h0000_0011, 1'b0, 8'h00, 8'h5A);

        // Unmapped I/O address: read zero, write ignored
        applyStimulus(32'h0003_0008, 1'b1, 8'h77, 8'h00);
        checkOutput("unmapped_wr_tx_valid", tx_valid, 0);
        applyStimulus(32'h0003_0008, 1'b0, 8'h00, 8'h00);

        // Fill TX with the UART stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            txQ.push_back(8'h41 + 8'(i));
            applyStimulus(32'h0003_0000, 1'b1, 8'h41 + 8'(i), 8'h00);
            if (i == 4) checkOutput("ibf_after5", io_buffer_full, 0);
            if (i == 5) checkOutput("ibf_after6", io_buffer_full, 1);
            if (i == 7) begin
                checkOutput("ibf_after8", io_buffer_full, 1);
                checkOutput("ovf_after8", tx_overflow, 0);
            end
        end
        // Ninth write with a simultaneous pop: still dropped
        tx_ready = 1'b1;
        applyStimulus(32'h0003_0000, 1'b1, 8'h49, 8'h00);
        checkOutput("ovf_after9", tx_overflow, 1);
        for (int n = 0; n < 20 && txQ.size() != 0; n++) idleCycle();
        checkOutput("tx_drain_left", txQ.size(), 0);
        idleCycle();
        checkOutput("tx_valid_drained", tx_valid, 0);
        checkOutput("ibf_drained", io_buffer_full, 0);
        tx_ready = 1'b0;
        applyStimulus(32'h0003_0000, 1'b1, 8'h00, 8'h00);
        checkOutput("zero_write_no_push", tx_valid, 0);

        // Streaming "Hi" with the UART ready
        tx_ready = 1'b1;
        txQ.push_back(8'h48);
        applyStimulus(32'h0003_0000, 1'b1, 8'h48, 8'h00);
        checkOutput("hi_ibf0", io_buffer_full, 0);
        checkOutput("hi_valid0", tx_valid, 1);
        txQ.push_back(8'h69);
        applyStimulus(32'h0003_0000, 1'b1, 8'h69, 8'h00);
        checkOutput("hi_ibf1", io_buffer_full, 0);
        idleCycle();
        checkOutput("hi_ibf2", io_buffer_full, 0);
        idleCycle();
        checkOutput("hi_drained", txQ.size(), 0);
        checkOutput("hi_valid_end", tx_valid, 0);
        checkOutput("ovf_sticky", tx_overflow, 1);
        tx_ready = 1'b0;

        // RX pushes then three reads, the last on an empty FIFO
        rx_valid = 1'b1;
        rx_data  = 8'h31;
        idleCycle();
        rx_data  = 8'h32;
        idleCycle();
        rx_valid = 1'b0;
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 8'h31);
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 8'h32);
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 8'h00);

        // Fill RX with no reads, one extra offer is refused
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'h50 + 8'(i);
            idleCycle();
            if (i == 6) checkOutput("rx_ready_after7", rx_ready, 1);
            if (i == 7) checkOutput("rx_ready_after8", rx_ready, 0);
        end
        rx_data = 8'h5F;
        idleCycle();
        rx_valid = 1'b0;
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 8'h50);
        checkOutput("rx_ready_after_pop", rx_ready, 1);
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 8'h51);

        // Counter snapshot: read the word when the low byte is 0xFF
        for (int n = 0; n < 600 && modelCounter != 32'h0000_00FF; n++) idleCycle();
        checkOutput("ctr_reached_ff", modelCounter, 32'h0000_00FF);
        snap = modelCounter;
        applyStimulus(32'h0003_0004, 1'b0, 8'h00, snap[7:0]);
        applyStimulus(32'h0003_0005, 1'b0, 8'h00, snap[15:8]);
        applyStimulus(32'h0003_0006, 1'b0, 8'h00, snap[23:16]);
        applyStimulus(32'h0003_0007, 1'b0, 8'h00, snap[31:24]);
        // Again at 0x1FF, where the live upper byte moves on before it is read
        for (int n = 0; n < 600 && modelCounter != 32'h0000_01FF; n++) idleCycle();
        checkOutput("ctr_reached_1ff", modelCounter, 32'h0000_01FF);
        snap = modelCounter;
        applyStimulus(32'h0003_0004, 1'b0, 8'h00, snap[7:0]);
        applyStimulus(32'h0003_0005, 1'b0, 8'h00, snap[15:8]);
        applyStimulus(32'h0003_0006, 1'b0, 8'h00, snap[23:16]);

        // Stop write pushes 0x00, then more bytes to reach near-full
        tx_ready = 1'b0;
        txQ.push_back(8'h00);
        applyStimulus(32'h0003_0004, 1'b1, 8'h12, 8'h00);
        checkOutput("pd_set", program_done, 1);
        checkOutput("pd_tx_valid", tx_valid, 1);
        checkOutput("pd_tx_data", tx_data, 0);
        for (int i = 0; i < 6; i++) begin
            txQ.push_back(8'h61 + 8'(i));
            applyStimulus(32'h0003_0000, 1'b1, 8'h61 + 8'(i), 8'h00);
        end
        checkOutput("pre_rst_ibf", io_buffer_full, 1);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        idleCycle();
        rx_valid = 1'b0;

        // Reset mid-stream with a RAM read in flight
        rst_in = 1'b1;
        applyStimulus(32'h0000_0010, 1'b0, 8'h00, 8'h00);
        rst_in = 1'b0;
        txQ.delete();
        checkOutput("mid_rst_tx_valid", tx_valid, 0);
        checkOutput("mid_rst_rx_ready", rx_ready, 1);
        checkOutput("mid_rst_ibf", io_buffer_full, 0);
        checkOutput("mid_rst_program_done", program_done, 0);
        checkOutput("mid_rst_tx_overflow", tx_overflow, 0);
        tx_ready = 1'b1;
        applyStimulus(32'h0003_0004, 1'b0, 8'h00, modelCounter[7:0]);
        applyStimulus(32'h0003_0005, 1'b0, 8'h00, 8'h00);
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 8'h00);
        applyStimulus(32'h0000_0010, 1'b0, 8'h00, 8'hA5);
        idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
